// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone RAM arbiter.
// Holds the FSM state encoding, the default watchdog limit and the index-width helper.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StAbort
  } arb_state_e;

  localparam int unsigned DefaultTimeout = 255;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin requester selection: returns the first requester after last_owner, one-hot.
module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned NbMasters = 2
) (
  input  logic [NbMasters-1:0]            req,
  input  logic [idx_width(NbMasters)-1:0] last_owner,
  output logic [NbMasters-1:0]            choice
);

  localparam int unsigned IdxW = idx_width(NbMasters);

  logic [IdxW-1:0] idx;
  logic            found;

  // Offset NbMasters wraps back to last_owner itself, so a lone owner can re-win.
  always_comb begin
    choice = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned off = 1; off <= NbMasters; off++) begin
      idx = IdxW'((32'(last_owner) + off) % NbMasters);
      if (!found && req[idx]) begin
        choice[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin arbiter sharing one Wishbone RAM slave port among NB_MASTERS masters.
// Define WB_ARB_WATCHDOG_EN to build in the ACK watchdog (ABORT state, ERR and timeout_irq).
module wb_ram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NB_MASTERS = 2,
  parameter int unsigned TIMEOUT    = DefaultTimeout
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic [NB_MASTERS-1:0]    m_wb_CYC_I,
  input  logic [NB_MASTERS-1:0]    m_wb_STB_I,
  input  logic [NB_MASTERS-1:0]    m_wb_WE_I,
  input  logic [NB_MASTERS-1:0]    m_wb_LOCK_I,
  input  logic [32*NB_MASTERS-1:0] m_wb_ADR_I,
  input  logic [32*NB_MASTERS-1:0] m_wb_DAT_I,
  input  logic [4*NB_MASTERS-1:0]  m_wb_SEL_I,
  output logic [31:0]              m_wb_DAT_O,
  output logic [NB_MASTERS-1:0]    m_wb_ACK_O,
  output logic [NB_MASTERS-1:0]    m_wb_ERR_O,
  output logic                     s_wb_CYC_O,
  output logic                     s_wb_STB_O,
  output logic                     s_wb_WE_O,
  output logic                     s_wb_LOCK_O,
  output logic [31:0]              s_wb_ADR_O,
  output logic [31:0]              s_wb_DAT_O,
  output logic [3:0]               s_wb_SEL_O,
  input  logic [31:0]              s_wb_DAT_I,
  input  logic                     s_wb_ACK_I,
  output logic [NB_MASTERS-1:0]    grant,
  output logic                     timeout_irq
);

  localparam int unsigned IdxW = idx_width(NB_MASTERS);

  arb_state_e            state_q, state_d;
  logic [NB_MASTERS-1:0] grant_q, grant_d, pick;
  logic [IdxW-1:0]       last_owner_q, last_owner_d, owner;
  logic                  own_cyc, own_stb, own_we, own_lock;
  logic [31:0]           own_adr, own_dat;
  logic [3:0]            own_sel;

  rr_pick #(
    .NbMasters (NB_MASTERS)
  ) u_rr_pick (
    .req        (m_wb_CYC_I),
    .last_owner (last_owner_q),
    .choice     (pick)
  );

  // Owner's bus signals, selected by the one-hot grant register.
  always_comb begin
    owner    = '0;
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    own_we   = 1'b0;
    own_lock = 1'b0;
    own_adr  = '0;
    own_dat  = '0;
    own_sel  = '0;
    for (int i = 0; i < NB_MASTERS; i++) begin
      if (grant_q[i]) begin
        owner    = IdxW'(i);
        own_cyc  = m_wb_CYC_I[i];
        own_stb  = m_wb_STB_I[i];
        own_we   = m_wb_WE_I[i];
        own_lock = m_wb_LOCK_I[i];
        own_adr  = m_wb_ADR_I[32*i +: 32];
        own_dat  = m_wb_DAT_I[32*i +: 32];
        own_sel  = m_wb_SEL_I[4*i +: 4];
      end
    end
  end

`ifdef WB_ARB_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_hit;

  always_comb begin
    wd_cnt_d = '0;
    wd_hit   = 1'b0;
    if (state_q == StBusy && own_stb && !s_wb_ACK_I) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      wd_hit   = (32'(wd_cnt_d) >= TIMEOUT);
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    s_wb_CYC_O   = 1'b0;
    s_wb_STB_O   = 1'b0;
    s_wb_WE_O    = 1'b0;
    s_wb_LOCK_O  = 1'b0;
    s_wb_ADR_O   = '0;
    s_wb_DAT_O   = '0;
    s_wb_SEL_O   = '0;
    m_wb_ACK_O   = '0;
    m_wb_ERR_O   = '0;
    timeout_irq  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|m_wb_CYC_I) begin
          grant_d = pick;
          state_d = StBusy;
        end
      end
      StBusy: begin
        s_wb_CYC_O  = own_cyc;
        s_wb_STB_O  = own_stb;
        s_wb_WE_O   = own_we;
        s_wb_LOCK_O = own_lock;
        s_wb_ADR_O  = own_adr;
        s_wb_DAT_O  = own_dat;
        s_wb_SEL_O  = own_sel;
        m_wb_ACK_O  = grant_q & {NB_MASTERS{s_wb_ACK_I}};
        // LOCK pins the grant even while the owner's CYC is low.
        if (!own_cyc && !own_lock) begin
          state_d      = StIdle;
          grant_d      = '0;
          last_owner_d = owner;
        end
`ifdef WB_ARB_WATCHDOG_EN
        else if (wd_hit) begin
          state_d = StAbort;
        end
`endif
      end
      StAbort: begin
`ifdef WB_ARB_WATCHDOG_EN
        m_wb_ERR_O  = grant_q;
        timeout_irq = 1'b1;
`endif
        state_d      = StIdle;
        grant_d      = '0;
        last_owner_d = owner;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_owner_q <= IdxW'(NB_MASTERS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign grant      = grant_q;
  assign m_wb_DAT_O = s_wb_DAT_I;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed self-checking bench for wb_ram_arbiter with two masters.
// Watchdog scenario checks ERR/IRQ when WB_ARB_WATCHDOG_EN is defined, else that they stay 0.
module tb_wb_ram_arbiter;

  logic        clk = 1'b0;
  logic        RST;
  logic [1:0]  cyc, stb, we, lock;
  logic [63:0] adr, wdat;
  logic [7:0]  sel;
  logic [31:0] m_dat_o;
  logic [1:0]  ack, err, grant;
  logic        s_cyc, s_stb, s_we, s_lock, irq;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic [3:0]  s_sel;
  logic        s_ack;

  int checks = 0;
  int errors = 0;

  wb_ram_arbiter #(
    .NB_MASTERS (2),
    .TIMEOUT    (8)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .m_wb_CYC_I  (cyc),
    .m_wb_STB_I  (stb),
    .m_wb_WE_I   (we),
    .m_wb_LOCK_I (lock),
    .m_wb_ADR_I  (adr),
    .m_wb_DAT_I  (wdat),
    .m_wb_SEL_I  (sel),
    .m_wb_DAT_O  (m_dat_o),
    .m_wb_ACK_O  (ack),
    .m_wb_ERR_O  (err),
    .s_wb_CYC_O  (s_cyc),
    .s_wb_STB_O  (s_stb),
    .s_wb_WE_O   (s_we),
    .s_wb_LOCK_O (s_lock),
    .s_wb_ADR_O  (s_adr),
    .s_wb_DAT_O  (s_dat_o),
    .s_wb_SEL_O  (s_sel),
    .s_wb_DAT_I  (s_dat_i),
    .s_wb_ACK_I  (s_ack),
    .grant       (grant),
    .timeout_irq (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    cyc = '0; stb = '0; we = '0; lock = '0;
    adr = '0; wdat = '0; sel = '0; s_dat_i = '0; s_ack = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    s_dat_i = 32'h5A5A_0F0F;
    #1;
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant); end
    checks++;
    if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin
      errors++; $display("FAIL reset_s_ctl got cyc=%b stb=%b want 0 0", s_cyc, s_stb);
    end
    checks++;
    if (ack !== 2'b00 || err !== 2'b00 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_ack_err got ack=%b err=%b irq=%b want 0", ack, err, irq);
    end
    checks++;
    if (m_dat_o !== 32'h5A5A_0F0F) begin
      errors++; $display("FAIL dat_passthru got %h want 5a5a0f0f", m_dat_o);
    end
  endtask

  task automatic test_round_robin();
    adr = {32'h2000_0004, 32'h1000_0000};
    cyc = 2'b11; stb = 2'b11;
    #1;
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL rr_latency got %b want 00", grant); end
    tick();
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL rr_first got %b want 01", grant); end
    checks++;
    if (s_cyc !== 1'b1 || s_adr !== 32'h1000_0000) begin
      errors++; $display("FAIL rr_route0 got cyc=%b adr=%h want 1 10000000", s_cyc, s_adr);
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    tick();
    checks++;
    if (grant !== 2'b00 || s_cyc !== 1'b0) begin
      errors++; $display("FAIL rr_dead got grant=%b cyc=%b want 00 0", grant, s_cyc);
    end
    tick();
    checks++;
    if (grant !== 2'b10 || s_adr !== 32'h2000_0004) begin
      errors++; $display("FAIL rr_second got grant=%b adr=%h want 10 20000004", grant, s_adr);
    end
    cyc = '0; stb = '0;
    tick();
    tick();
  endtask

  task automatic test_lock();
    cyc = 2'b10; stb = 2'b10; lock = 2'b10;
    tick();
    checks++;
    if (grant !== 2'b10) begin errors++; $display("FAIL lock_grant got %b want 10", grant); end
    cyc = 2'b01; stb = 2'b01;
    #1;
    checks++;
    if (s_cyc !== 1'b0 || s_lock !== 1'b1) begin
      errors++; $display("FAIL lock_route got cyc=%b lock=%b want 0 1", s_cyc, s_lock);
    end
    tick();
    checks++;
    if (grant !== 2'b10) begin errors++; $display("FAIL lock_hold_cyc0 got %b want 10", grant); end
    cyc = 2'b11;
    tick();
    checks++;
    if (grant !== 2'b10) begin errors++; $display("FAIL lock_hold_cyc1 got %b want 10", grant); end
    cyc = 2'b01; stb = 2'b01; lock = 2'b00;
    tick();
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL lock_release got %b want 00", grant); end
    tick();
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL lock_next got %b want 01", grant); end
    cyc = '0; stb = '0;
    tick();
    tick();
  endtask

  task automatic test_read();
    adr = {32'h0000_1000, 32'h0};
    we = 2'b00; cyc = 2'b10; stb = 2'b10;
    tick();
    checks++;
    if (grant !== 2'b10 || s_adr !== 32'h0000_1000 || s_we !== 1'b0 || s_stb !== 1'b1) begin
      errors++;
      $display("FAIL read_route got grant=%b adr=%h we=%b stb=%b want 10 00001000 0 1",
               grant, s_adr, s_we, s_stb);
    end
    s_dat_i = 32'hAABB_CCDD; s_ack = 1'b1;
    #1;
    checks++;
    if (ack !== 2'b10) begin errors++; $display("FAIL read_ack got %b want 10", ack); end
    checks++;
    if (m_dat_o !== 32'hAABB_CCDD) begin
      errors++; $display("FAIL read_data got %h want aabbccdd", m_dat_o);
    end
    tick();
    s_ack = 1'b0; cyc = '0; stb = '0;
    tick();
    tick();
  endtask

  task automatic test_write();
    adr = {32'h0, 32'h0000_0040};
    wdat = {32'hDEAD_BEEF, 32'h1234_5678};
    sel = 8'hF6; we = 2'b01; cyc = 2'b01; stb = 2'b01;
    tick();
    checks++;
    if (grant !== 2'b01 || s_dat_o !== 32'h1234_5678 || s_sel !== 4'b0110 || s_we !== 1'b1) begin
      errors++;
      $display("FAIL write_route got grant=%b dat=%h sel=%b we=%b want 01 12345678 0110 1",
               grant, s_dat_o, s_sel, s_we);
    end
    s_ack = 1'b1;
    #1;
    checks++;
    if (ack !== 2'b01) begin errors++; $display("FAIL write_ack got %b want 01", ack); end
    tick();
    s_ack = 1'b0; cyc = '0; stb = '0; we = '0; sel = '0;
    tick();
    tick();
  endtask

  task automatic test_single();
    cyc = 2'b01; stb = 2'b01;
    tick();
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL single_first got %b want 01", grant); end
    cyc = '0; stb = '0;
    tick();
    checks++;
    if (grant !== 2'b00) begin errors++; $display("FAIL single_dead got %b want 00", grant); end
    cyc = 2'b01; stb = 2'b01;
    tick();
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL single_regrant got %b want 01", grant); end
    cyc = '0; stb = '0;
    tick();
    tick();
  endtask

  task automatic test_watchdog();
    cyc = 2'b01; stb = 2'b01; s_ack = 1'b0;
    tick();
`ifdef WB_ARB_WATCHDOG_EN
    // Wait cycles 2..8 must not yet abort.
    for (int k = 2; k <= 8; k++) begin
      tick();
      checks++;
      if (err !== 2'b00 || irq !== 1'b0 || grant !== 2'b01) begin
        errors++;
        $display("FAIL wd_wait%0d got err=%b irq=%b grant=%b want 00 0 01", k, err, irq, grant);
      end
    end
    tick();
    checks++;
    if (err !== 2'b01 || irq !== 1'b1 || s_cyc !== 1'b0) begin
      errors++;
      $display("FAIL wd_abort got err=%b irq=%b cyc=%b want 01 1 0", err, irq, s_cyc);
    end
    cyc = '0; stb = '0;
    tick();
    checks++;
    if (err !== 2'b00 || irq !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL wd_idle got err=%b irq=%b grant=%b want 00 0 00", err, irq, grant);
    end
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (err !== 2'b00 || irq !== 1'b0 || grant !== 2'b01) begin
        errors++;
        $display("FAIL nowd_stall%0d got err=%b irq=%b grant=%b want 00 0 01", k, err, irq, grant);
      end
    end
    cyc = '0; stb = '0;
    tick();
`endif
    tick();
  endtask

  task automatic test_reset_mid_busy();
    cyc = 2'b10; stb = 2'b10;
    tick();
    checks++;
    if (grant !== 2'b10) begin errors++; $display("FAIL rstbusy_grant got %b want 10", grant); end
    RST = 1'b1; s_ack = 1'b1;
    tick();
    checks++;
    if (grant !== 2'b00 || s_cyc !== 1'b0 || ack !== 2'b00) begin
      errors++;
      $display("FAIL rstbusy_drop got grant=%b cyc=%b ack=%b want 00 0 00", grant, s_cyc, ack);
    end
    RST = 1'b0; s_ack = 1'b0; cyc = 2'b11; stb = 2'b11;
    tick();
    checks++;
    if (grant !== 2'b01) begin errors++; $display("FAIL rstbusy_first got %b want 01", grant); end
    cyc = '0; stb = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_read();
    test_write();
    test_single();
    test_watchdog();
    test_reset_mid_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
